// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson sequencing controller: FSM state enum,
// legal-code generator, legality check and phase decode (all sized up to MAX_W stages).
package johnson_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

    localparam int unsigned MAX_W = 32;

    // Code reached after p advances from all-zeros in a w-stage ring.
    function automatic logic [MAX_W-1:0] legal_code(input int unsigned p, input int unsigned w);
        logic [MAX_W-1:0] code;
        code = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                code[i] = (p <= w) ? (i < p) : (i >= p - w);
            end
        end
        return code;
    endfunction

    function automatic logic is_legal(input logic [MAX_W-1:0] q, input int unsigned w);
        logic hit;
        hit = 1'b0;
        for (int unsigned p = 0; p < 2 * MAX_W; p++) begin
            if (p < 2 * w && q == legal_code(p, w)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic int unsigned phase_of(input logic [MAX_W-1:0] q, input int unsigned w);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                ones = ones + 32'(q[i]);
            end
        end
        return q[w-1] ? (2 * w - ones) : ones;
    endfunction

endpackage

// File: rtl/johnson_ring.sv
// WIDTH-stage twisted-ring register with async reset, advance enable and synchronous clear.
module johnson_ring #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Commanded phase generator around a Johnson ring: counted/free runs, pause, abort, done, wrap.
// Optional illegal-code checker enabled by defining JOHNSON_ILLEGAL_DET_EN.
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned PH_W = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  phase,
    output logic             wrap,
    output logic             err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             wrap_q, wrap_d;
    logic             adv, clr, illegal;

    johnson_ring #(
        .WIDTH(WIDTH)
    ) u_ring (
        .clk(clk),
        .rst(rst),
        .en (adv),
        .clr(clr),
        .q  (q)
    );

    assign phase = PH_W'(phase_of(MAX_W'(q), WIDTH));

`ifdef JOHNSON_ILLEGAL_DET_EN
    logic err_q;

    assign illegal = ~is_legal(MAX_W'(q), WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (illegal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        adv     = 1'b0;
        clr     = 1'b0;
        if (abort || illegal) begin
            state_d = IDLE;
            rem_d   = '0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        rem_d   = len;
                    end
                end
                // A HOLD cycle with pause low advances, so each HOLD cycle costs one cycle.
                RUN, HOLD: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else begin
                        adv     = 1'b1;
                        state_d = RUN;
                        if (rem_q != '0) begin
                            rem_d = rem_q - CNT_W'(1);
                            if (rem_q == CNT_W'(1)) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Only a real advance out of the last phase reports wrap; a clear never does.
    assign wrap_d = adv && (phase == PH_W'(2 * WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == HOLD);
    assign done = (state_q == DONE);
    assign wrap = wrap_q;

endmodule
